// File: rtl/ps_trigger_pkg.sv
// ps_trigger_pkg
// Shared constants and types for the power-supply trigger link framer.
//   K28_1 / K28_5   : K-codes used as start/end-of-packet markers
//   CMD_*_CODE      : default command bytes for trigger and set-point frames
//   frame_state_t   : sequencing states of the frame generator
package ps_trigger_pkg;

    localparam logic [7:0] K28_1         = 8'h3C;
    localparam logic [7:0] K28_5         = 8'hBC;
    localparam logic [7:0] CMD_TRIG_CODE = 8'h70;
    localparam logic [7:0] CMD_SET_CODE  = 8'h40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOP,
        ST_ADDR,
        ST_CMD,
        ST_PAY,
        ST_CSUM,
        ST_EOP
    } frame_state_t;

endpackage

// File: rtl/ps_frame_gen.sv
// ps_frame_gen
// Sequenced byte-stream framer for the power-supply trigger link. Emits
// SOP, address, command, PAYLOAD_BYTES payload bytes, an optional XOR
// checksum and EOP towards the 8b/10b serialiser. Trigger pulses take
// priority over handshaked set-point requests.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   trig_pulse        : single-cycle trigger request
//   req_valid/ready   : set-point frame request handshake
//   req_addr          : set-point address byte
//   req_payload       : set-point payload, byte 0 in [7:0] sent first
//   tx_data/k/valid   : registered output byte, K-flag and valid
//   tx_ready          : serialiser accepts byte when tx_valid & tx_ready
//   tx_sof/tx_eof     : marks SOP / EOP byte
//   trig_overrun      : one-cycle pulse when a trigger is coalesced
//   frame_cnt         : number of completed frames, wraps
module ps_frame_gen
    import ps_trigger_pkg::*;
#(
    parameter int unsigned PAYLOAD_BYTES = 6,
    parameter bit          CHECKSUM_EN   = 1'b0,
    parameter logic [7:0]  SOP           = K28_1,
    parameter logic [7:0]  EOP           = K28_5,
    parameter logic [7:0]  CMD_TRIG      = CMD_TRIG_CODE,
    parameter logic [7:0]  CMD_SET       = CMD_SET_CODE,
    parameter logic [7:0]  TRIG_ADDR     = 8'h00
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         trig_pulse,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [7:0]                   req_addr,
    input  logic [8*PAYLOAD_BYTES-1:0]   req_payload,
    output logic [7:0]                   tx_data,
    output logic                         tx_k,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         tx_sof,
    output logic                         tx_eof,
    output logic                         trig_overrun,
    output logic [15:0]                  frame_cnt
);

    localparam int unsigned IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

    frame_state_t                 state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [7:0]                   addr_q, addr_d;
    logic [7:0]                   cmd_q, cmd_d;
    logic [8*PAYLOAD_BYTES-1:0]   payload_q, payload_d;
    logic [7:0]                   csum_q, csum_d;
    logic                         trig_pending_q, trig_pending_d;
    logic                         trig_overrun_q, trig_overrun_d;
    logic [15:0]                  frame_cnt_q, frame_cnt_d;
    logic [7:0]                   tx_data_q, tx_data_d;
    logic                         tx_k_q, tx_k_d;
    logic                         tx_valid_q, tx_valid_d;
    logic                         tx_sof_q, tx_sof_d;
    logic                         tx_eof_q, tx_eof_d;
    logic                         fire;
    logic                         trig_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            addr_q         <= '0;
            cmd_q          <= '0;
            payload_q      <= '0;
            csum_q         <= '0;
            trig_pending_q <= 1'b0;
            trig_overrun_q <= 1'b0;
            frame_cnt_q    <= '0;
            tx_data_q      <= '0;
            tx_k_q         <= 1'b0;
            tx_valid_q     <= 1'b0;
            tx_sof_q       <= 1'b0;
            tx_eof_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            addr_q         <= addr_d;
            cmd_q          <= cmd_d;
            payload_q      <= payload_d;
            csum_q         <= csum_d;
            trig_pending_q <= trig_pending_d;
            trig_overrun_q <= trig_overrun_d;
            frame_cnt_q    <= frame_cnt_d;
            tx_data_q      <= tx_data_d;
            tx_k_q         <= tx_k_d;
            tx_valid_q     <= tx_valid_d;
            tx_sof_q       <= tx_sof_d;
            tx_eof_q       <= tx_eof_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        addr_d         = addr_q;
        cmd_d          = cmd_q;
        payload_d      = payload_q;
        csum_d         = csum_q;
        trig_pending_d = trig_pending_q;
        trig_overrun_d = 1'b0;
        frame_cnt_d    = frame_cnt_q;
        tx_data_d      = 8'h00;
        tx_k_d         = 1'b0;
        tx_valid_d     = 1'b0;
        tx_sof_d       = 1'b0;
        tx_eof_d       = 1'b0;

        fire      = tx_valid_q & tx_ready;
        trig_take = (state_q == ST_IDLE) & (trig_pulse | trig_pending_q);

        case (state_q)
            ST_IDLE: begin
                idx_d  = '0;
                csum_d = '0;
                if (trig_take) begin
                    state_d   = ST_SOP;
                    addr_d    = TRIG_ADDR;
                    cmd_d     = CMD_TRIG;
                    payload_d = '0;
                end else if (req_valid) begin
                    state_d   = ST_SOP;
                    addr_d    = req_addr;
                    cmd_d     = CMD_SET;
                    payload_d = req_payload;
                end
            end
            ST_SOP: begin
                if (fire) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (fire) begin
                    csum_d  = csum_q ^ addr_q;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (fire) begin
                    csum_d  = csum_q ^ cmd_q;
                    state_d = ST_PAY;
                end
            end
            ST_PAY: begin
                // Payload is shifted down so the byte on the wire is always [7:0].
                if (fire) begin
                    csum_d    = csum_q ^ payload_q[7:0];
                    payload_d = payload_q >> 8;
                    if (idx_q == LAST_IDX) begin
                        state_d = CHECKSUM_EN ? ST_CSUM : ST_EOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_CSUM: begin
                if (fire) state_d = ST_EOP;
            end
            ST_EOP: begin
                if (fire) begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A pulse landing in the consume cycle re-arms pending instead of being lost.
        if (trig_take) begin
            trig_pending_d = trig_pulse & trig_pending_q;
        end else if (trig_pulse) begin
            trig_pending_d = 1'b1;
            trig_overrun_d = trig_pending_q;
        end

        // Output byte is registered from the next state, so stalls hold it naturally.
        tx_valid_d = (state_d != ST_IDLE);
        case (state_d)
            ST_SOP: begin
                tx_data_d = SOP;
                tx_k_d    = 1'b1;
                tx_sof_d  = 1'b1;
            end
            ST_ADDR: tx_data_d = addr_d;
            ST_CMD:  tx_data_d = cmd_d;
            ST_PAY:  tx_data_d = payload_d[7:0];
            ST_CSUM: tx_data_d = csum_d;
            ST_EOP: begin
                tx_data_d = EOP;
                tx_k_d    = 1'b1;
                tx_eof_d  = 1'b1;
            end
            default: tx_data_d = 8'h00;
        endcase
    end

    assign req_ready    = rst_n & (state_q == ST_IDLE) & ~trig_pulse & ~trig_pending_q;
    assign tx_data      = tx_data_q;
    assign tx_k         = tx_k_q;
    assign tx_valid     = tx_valid_q;
    assign tx_sof       = tx_sof_q;
    assign tx_eof       = tx_eof_q;
    assign trig_overrun = trig_overrun_q;
    assign frame_cnt    = frame_cnt_q;

endmodule
